// File: rtl/sample_fetch_scheduler_if.sv
// Read-port bundle between the fetch scheduler (master) and the shared sample RAM (slave).
interface sample_fetch_scheduler_if #(
    parameter int WW_WIDTH     = 18,
    parameter int SAMPLE_WIDTH = 16
);
    logic [WW_WIDTH-1:0]     ram_addr_out;
    logic                    ram_en_out;
    logic [SAMPLE_WIDTH-1:0] ram_data_in;

    modport master (output ram_addr_out, output ram_en_out, input ram_data_in);
    modport slave  (input ram_addr_out, input ram_en_out, output ram_data_in);
endinterface

// File: rtl/sample_fetch_scheduler.sv
// Per-frame scheduler sharing one sample RAM read port across all voices; publishes the
// gathered samples to the mixer in a single atomic update.
module sample_fetch_scheduler #(
    parameter int NUM_VOICES   = 8,
    parameter int WW_WIDTH     = 18,
    parameter int SAMPLE_WIDTH = 16,
    parameter int RAM_LATENCY  = 2
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               frame_start_in,
    input  logic [NUM_VOICES-1:0]              voice_active_in,
    input  logic [NUM_VOICES*WW_WIDTH-1:0]     sample_index_in,
    sample_fetch_scheduler_if.master           ram,
    output logic [NUM_VOICES*SAMPLE_WIDTH-1:0] sample_data_out,
    output logic                               frame_done_out,
    output logic                               busy_out,
    output logic                               overrun_out
);
    localparam int VID_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                            state_reg;
    logic [NUM_VOICES-1:0]             pending_reg;
    logic [NUM_VOICES*WW_WIDTH-1:0]    index_snap_reg;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] shadow_reg;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] shadow_next;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] data_out_reg;
    logic [WW_WIDTH-1:0]               addr_reg;
    logic                              en_reg;
    logic                              done_reg;
    logic                              overrun_reg;

    // Stage 0 travels with the registered read request; the tag in the last stage lines up
    // with the RAM data for that request.
    logic [RAM_LATENCY:0]              tag_valid_reg;
    logic [VID_W-1:0]                  tag_id_reg [0:RAM_LATENCY];

    logic [VID_W-1:0]                  sel_id;
    logic                              sel_valid;
    logic [NUM_VOICES-1:0]             sel_onehot;
    logic [NUM_VOICES-1:0]             pending_next;
    logic                              capture_valid;
    logic [VID_W-1:0]                  capture_id;
    logic                              in_flight;

    always_comb begin
        sel_id     = '0;
        sel_valid  = |pending_reg;
        sel_onehot = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                sel_id = VID_W'(i);
            end
        end
        sel_onehot[sel_id] = sel_valid;
        pending_next       = pending_reg & ~sel_onehot;
    end

    assign capture_valid = tag_valid_reg[RAM_LATENCY];
    assign capture_id    = tag_id_reg[RAM_LATENCY];
    assign in_flight     = |tag_valid_reg[RAM_LATENCY-1:0];

    // The final capture lands on the same edge as the publish, so publish from shadow_next.
    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_shadow
            assign shadow_next[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                (capture_valid && capture_id == VID_W'(gi)) ? ram.ram_data_in
                                                            : shadow_reg[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg      <= IDLE;
            pending_reg    <= '0;
            index_snap_reg <= '0;
            shadow_reg     <= '0;
            data_out_reg   <= '0;
            addr_reg       <= '0;
            en_reg         <= 1'b0;
            done_reg       <= 1'b0;
            overrun_reg    <= 1'b0;
            tag_valid_reg  <= '0;
            for (int j = 0; j <= RAM_LATENCY; j++) begin
                tag_id_reg[j] <= '0;
            end
        end else begin
            en_reg           <= 1'b0;
            addr_reg         <= '0;
            done_reg         <= 1'b0;
            overrun_reg      <= frame_start_in && (state_reg != IDLE);
            shadow_reg       <= shadow_next;
            tag_valid_reg[0] <= 1'b0;
            tag_id_reg[0]    <= '0;
            for (int j = 1; j <= RAM_LATENCY; j++) begin
                tag_valid_reg[j] <= tag_valid_reg[j-1];
                tag_id_reg[j]    <= tag_id_reg[j-1];
            end

            case (state_reg)
                IDLE: begin
                    if (frame_start_in) begin
                        pending_reg    <= voice_active_in;
                        index_snap_reg <= sample_index_in;
                        shadow_reg     <= '0;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sel_valid) begin
                        en_reg           <= 1'b1;
                        addr_reg         <= index_snap_reg[int'(sel_id)*WW_WIDTH +: WW_WIDTH];
                        tag_valid_reg[0] <= 1'b1;
                        tag_id_reg[0]    <= sel_id;
                    end
                    pending_reg <= pending_next;
                    if (pending_next == '0) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!in_flight) begin
                        data_out_reg <= shadow_next;
                        done_reg     <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ram.ram_addr_out = addr_reg;
    assign ram.ram_en_out   = en_reg;
    assign sample_data_out  = data_out_reg;
    assign frame_done_out   = done_reg;
    assign overrun_out      = overrun_reg;
    assign busy_out         = (state_reg != IDLE);
endmodule

// File: tb/tb_sample_fetch_scheduler.sv
// Directed bench: each frame is driven from IDLE, and reads, done timing, overrun and published data are compared.
module tb_sample_fetch_scheduler;
    localparam int NV = 8;
    localparam int WW = 18;
    localparam int SW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic [NV-1:0]     voice_active = '0;
    logic [NV*WW-1:0]  sample_index = '0;
    logic [NV*SW-1:0]  sample_data;
    logic              frame_done;
    logic              busy;
    logic              overrun;

    int n_chk = 0;
    int n_bad = 0;

    sample_fetch_scheduler_if #(.WW_WIDTH(WW), .SAMPLE_WIDTH(SW)) ram_bus ();

    sample_fetch_scheduler #(
        .NUM_VOICES(NV), .WW_WIDTH(WW), .SAMPLE_WIDTH(SW), .RAM_LATENCY(2)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .frame_start_in  (frame_start),
        .voice_active_in (voice_active),
        .sample_index_in (sample_index),
        .ram             (ram_bus.master),
        .sample_data_out (sample_data),
        .frame_done_out  (frame_done),
        .busy_out        (busy),
        .overrun_out     (overrun)
    );

    always #5 clk = ~clk;

    // Two-cycle RAM: word[n] = 16'h1000 + n (low 16 bits); junk when no read was issued.
    logic          ram_en_d = 1'b0;
    logic [WW-1:0] ram_addr_d = '0;
    logic [SW-1:0] ram_q = 16'hDEAD;
    always @(posedge clk) begin
        ram_en_d   <= ram_bus.ram_en_out;
        ram_addr_d <= ram_bus.ram_addr_out;
        ram_q      <= ram_en_d ? (16'h1000 + ram_addr_d[SW-1:0]) : 16'hDEAD;
    end
    assign ram_bus.ram_data_in = ram_q;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input string name, input logic [NV-1:0] mask, input logic [NV*WW-1:0] idx,
                             input int ovr_at, input int chg_at, input int rst_at,
                             input int exp_done, input logic [NV*SW-1:0] exp_data);
        logic [WW-1:0] exp_addr[$];
        int nreads = 0;
        int ndone = 0;
        int done_cyc = -1;
        int novr = 0;
        for (int v = 0; v < NV; v++) if (mask[v]) exp_addr.push_back(idx[v*WW +: WW]);
        @(negedge clk);
        voice_active = mask;
        sample_index = idx;
        frame_start  = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == ovr_at) frame_start = 1'b1;
            if (c == chg_at) begin
                voice_active = 8'hFF;
                sample_index = {NV{18'h15555}};
            end
            if (c == rst_at) rst = 1'b1;
            @(posedge clk);
            #1;
            if (ram_bus.ram_en_out) begin
                $display("%s: cycle %0d read addr=%0d", name, c, ram_bus.ram_addr_out);
                if (nreads < exp_addr.size()) begin
                    chk({name, "_addr"}, 128'(ram_bus.ram_addr_out), 128'(exp_addr[nreads]));
                    chk({name, "_read_cycle"}, 128'(c), 128'(nreads + 1));
                end
                nreads++;
            end
            if (frame_done) begin
                ndone++;
                done_cyc = c;
                $display("%s: cycle %0d frame_done data=%h", name, c, sample_data);
                chk({name, "_data"}, 128'(sample_data), 128'(exp_data));
            end
            if (overrun) novr++;
            if (c == rst_at) begin
                chk({name, "_rst_busy"}, 128'(busy), 128'(0));
                chk({name, "_rst_data"}, 128'(sample_data), 128'(0));
            end
            @(negedge clk);
            frame_start = 1'b0;
            rst = 1'b0;
        end
        chk({name, "_nreads"}, 128'(nreads), 128'(exp_addr.size()));
        chk({name, "_ndone"}, 128'(ndone), 128'(rst_at == 0 ? 1 : 0));
        if (rst_at == 0) chk({name, "_done_cycle"}, 128'(done_cyc), 128'(exp_done));
        chk({name, "_novr"}, 128'(novr), 128'(ovr_at != 0 ? 1 : 0));
        chk({name, "_idle_busy"}, 128'(busy), 128'(0));
        chk({name, "_hold_data"}, 128'(sample_data), 128'(exp_data));
        $display("%s: reads=%0d dones=%0d overruns=%0d", name, nreads, ndone, novr);
    endtask

    logic [NV*WW-1:0] iv;
    logic [NV*SW-1:0] all_data;
    logic [NV*SW-1:0] sparse_data;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", 128'(sample_data), 128'(0));
        chk("reset_done", 128'(frame_done), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_ovr", 128'(overrun), 128'(0));
        chk("reset_en", 128'(ram_bus.ram_en_out), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        iv = '0;
        for (int v = 0; v < NV; v++) iv[v*WW +: WW] = WW'(v);
        all_data = {16'h1007, 16'h1006, 16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000};
        run_frame("all8", 8'hFF, iv, 0, 0, 0, 11, all_data);

        iv = '0;
        iv[2*WW +: WW] = 18'd5;
        iv[5*WW +: WW] = 18'd300;
        iv[7*WW +: WW] = 18'h3FFFF;
        sparse_data = {16'h0FFF, 16'h0000, 16'h112C, 16'h0000, 16'h0000, 16'h1005, 16'h0000, 16'h0000};
        run_frame("sparse", 8'b1010_0100, iv, 0, 0, 0, 6, sparse_data);

        run_frame("empty", 8'h00, iv, 0, 0, 0, 2, '0);

        iv = '0;
        for (int v = 0; v < NV; v++) iv[v*WW +: WW] = WW'(v);
        run_frame("overrun", 8'hFF, iv, 3, 0, 0, 11, all_data);

        iv = '0;
        iv[1*WW +: WW] = 18'd100;
        iv[3*WW +: WW] = 18'h02000;
        iv[4*WW +: WW] = 18'd7;
        iv[6*WW +: WW] = 18'h3FF00;
        run_frame("midchg", 8'b0101_1010, iv, 0, 2, 0, 7,
                  {16'h0000, 16'h0F00, 16'h0000, 16'h1007, 16'h3000, 16'h0000, 16'h1064, 16'h0000});

        iv = '0;
        for (int v = 0; v < NV; v++) iv[v*WW +: WW] = WW'(v);
        run_frame("rst_drain", 8'hFF, iv, 0, 0, 9, 0, '0);

        iv = '0;
        iv[2*WW +: WW] = 18'd5;
        iv[5*WW +: WW] = 18'd300;
        iv[7*WW +: WW] = 18'h3FFFF;
        run_frame("after_rst", 8'b1010_0100, iv, 0, 0, 0, 6, sparse_data);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/sample_fetch_scheduler.md
Name: sample_fetch_scheduler

Overview:
- Time-multiplexes the single read port of the shared waveform sample RAM across NUM_VOICES oscillators.
- Once per audio frame it snapshots every voice's sample index and active flag, then issues one RAM read per active voice.
- It tracks returning data through a tag pipeline matched to the RAM read latency, then publishes all voice samples atomically to the mixer.
- Sits between the oscillator bank (sample indices) and the mixer; the mixer consumes sample_data_out on frame_done_out.

Parameters:
- NUM_VOICES, 8, number of oscillator voices sharing the RAM port (1..16).
- WW_WIDTH, 18, sample index / RAM address width.
- SAMPLE_WIDTH, 16, RAM data width per sample.
- RAM_LATENCY, 2, cycles from address presented to valid data (2 = HIGH_PERFORMANCE BRAM).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- frame_start_in  input  1  one-cycle audio frame strobe (e.g. 48 kHz tick)
- voice_active_in  input  NUM_VOICES  per-voice is_on flag
- sample_index_in  input  NUM_VOICES*WW_WIDTH  packed indices; voice i at [i*WW_WIDTH +: WW_WIDTH]
- ram_addr_out  output  WW_WIDTH  read address to shared RAM
- ram_en_out  output  1  read enable to shared RAM
- ram_data_in  input  SAMPLE_WIDTH  RAM read data
- sample_data_out  output  NUM_VOICES*SAMPLE_WIDTH  packed published samples (signed); voice i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- frame_done_out  output  1  one-cycle pulse; sample_data_out updated this cycle
- busy_out  output  1  high while a frame fetch is in progress
- overrun_out  output  1  one-cycle pulse when frame_start_in arrives while busy

Behaviour:
- Reset: every output is 0, including sample_data_out, the shadow buffer, the tag pipeline and the state. Reset has priority in every state and abandons any in-flight fetch with no done pulse.
- States:
  - IDLE -> ISSUE on frame_start_in.
  - ISSUE -> DRAIN after the last active voice is issued.
  - DRAIN -> DONE when the tag pipeline is empty.
  - DONE -> IDLE unconditionally.
- On the frame_start_in edge in IDLE:
  - Register voice_active_in and all sample_index_in into a snapshot. Later input changes do not affect this frame.
  - Clear the shadow buffer to 0, so inactive voices publish 0.
- ISSUE:
  - Each cycle, select the lowest-numbered pending active voice from the snapshot mask using a priority encoder.
  - Drive ram_addr_out = its index and ram_en_out = 1, then clear its pending bit. Inactive voices consume zero cycles.
  - Push tag {valid, voice id} into a RAM_LATENCY-deep shift pipeline.
  - ram_en_out = 0 and ram_addr_out = 0 in every other state.
- Capture: when a tag exits the pipeline (RAM_LATENCY cycles after issue), write ram_data_in into shadow[voice id].
- DONE: copy shadow to sample_data_out, pulse frame_done_out for 1 cycle, then return to IDLE.
- busy_out is 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
- Timing: frame_start_in sampled at edge t0; A = number of active voices.
  - The k-th issued address (k = 0..A-1) is presented during cycle t0+1+k.
  - frame_done_out is high during cycle t0+A+RAM_LATENCY+1 for A>0, and during cycle t0+2 for A=0 (pass through an empty DRAIN).
- frame_start_in while busy_out = 1: ignored, and overrun_out pulses that cycle. The current frame continues unaffected.
- frame_start_in during the DONE cycle also counts as overrun. A new frame can only start from IDLE.
- sample_data_out holds its value between frame_done_out pulses and never exposes partially filled data.
- Index values pass through unmodified. Wrap-around is the oscillator's responsibility, so index 0 and index 2^WW_WIDTH-1 are both legal addresses.

Test Plan:
- Reset, then all 8 voices active with indices 0..7 and RAM word[n] = 16'h1000+n; frame_start at t0 -> addresses 0..7 on t0+1..t0+8, done at t0+11, sample_data_out voice i = 16'h1000+i.
- Mask 8'b1010_0100, indices voice2=5, voice5=300, voice7=2^18-1 -> exactly 3 reads in consecutive cycles (5, 300, 262143), done at t0+6, voices 0,1,3,4,6 = 0.
- Mask all zero -> no ram_en_out, done at t0+2, all outputs 0.
- Second frame_start 3 cycles after the first, with all voices active -> overrun_out pulses once, first frame completes normally, exactly one frame_done_out.
- Change sample_index_in and voice_active_in mid-fetch -> published samples match the snapshot values from t0.
- Assert rst_in during DRAIN -> no frame_done_out, outputs 0, busy_out = 0 next cycle; a new frame afterward completes correctly.
